// File: rtl/net_phase_scheduler.sv
// net_phase_scheduler
//   Receive phase calibration sequencer shared by all network ports. A sweep
//   steps the deserializer phase through every tap. At each tap it waits for
//   the link to settle, then counts good packet ends and framing errors over
//   a fixed window. Finally it drives the centre of the longest circular run
//   of good taps. If no tap was good, the phase in use before the sweep is
//   restored.
//
//   Optional build macro NET_PHASE_SCHED_PERIODIC_EN: adds an idle timer
//   that starts a sweep automatically after RECAL_CYCLES idle cycles.
//
// Ports
//   clk         in   system clock, rising edge
//   resetn      in   asynchronous active-low reset
//   start       in   one-cycle sweep request (honoured only when idle)
//   rx_end_evt  in   one-cycle pulse per good packet end (clk domain)
//   rx_err_evt  in   one-cycle pulse per framing/CRC error (clk domain)
//   phase_shift out  phase tap applied to all ports, zero-extended
//   busy        out  sweep in progress (start through selection)
//   done        out  one-cycle pulse when a sweep completes
//   locked      out  last sweep found at least one good tap
//   best_phase  out  tap chosen by the last successful sweep
//   good_mask   out  per-tap good flags of the last sweep
module net_phase_scheduler #(
  parameter int PHASES        = 8,
  parameter int SETTLE_CYCLES = 256,
  parameter int WINDOW_CYCLES = 65536,
  parameter int MIN_PACKETS   = 4,
  parameter int RECAL_CYCLES  = 40000000
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic              rx_end_evt,
  input  logic              rx_err_evt,
  output logic [7:0]        phase_shift,
  output logic              busy,
  output logic              done,
  output logic              locked,
  output logic [7:0]        best_phase,
  output logic [PHASES-1:0] good_mask
);

  localparam int LW   = (PHASES > 1) ? $clog2(PHASES) : 1;
  localparam int NW   = $clog2(PHASES + 1);
  localparam int SW   = LW + 1;
  localparam int MAXC = (SETTLE_CYCLES > WINDOW_CYCLES) ? SETTLE_CYCLES : WINDOW_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam int GW   = $clog2(MIN_PACKETS + 1);

  localparam logic [LW-1:0] TAP_LAST    = LW'(PHASES - 1);
  localparam logic [SW-1:0] SCAN_LAST   = SW'(2 * PHASES - 1);
  localparam logic [NW-1:0] LEN_CAP     = NW'(PHASES);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] WINDOW_LAST = CW'(WINDOW_CYCLES - 1);
  localparam logic [GW-1:0] GOOD_SAT    = GW'(MIN_PACKETS);

  // Elaboration-time parameter sanity checks.
  if ((PHASES < 2) || (PHASES > 128) || ((PHASES & (PHASES - 1)) != 0)) begin : g_bad_phases
    $error("net_phase_scheduler: PHASES must be a power of two in 2..128");
  end
  if ((SETTLE_CYCLES < 1) || (WINDOW_CYCLES < 1) || (MIN_PACKETS < 1) || (RECAL_CYCLES < 2)) begin : g_bad_timing
    $error("net_phase_scheduler: timing parameters out of range");
  end

  typedef enum logic [2:0] {
    ST_IDLE, ST_SETTLE, ST_MEASURE, ST_NEXT, ST_SELECT, ST_DONE
  } state_t;

  state_t            state_r, state_s;
  logic [LW-1:0]     tap_r, tap_s;
  logic [LW-1:0]     phase_r, phase_s;
  logic [LW-1:0]     saved_r, saved_s;
  logic [CW-1:0]     cnt_r, cnt_s;
  logic [GW-1:0]     good_r, good_s;
  logic              err_r, err_s;
  logic [PHASES-1:0] mask_r, mask_s;
  logic              busy_r, busy_s;
  logic              done_r, done_s;
  logic              locked_r, locked_s;
  logic [LW-1:0]     best_r, best_s;
  logic [SW-1:0]     scan_r, scan_s;
  logic [NW-1:0]     cur_len_r, cur_len_s;
  logic [LW-1:0]     cur_start_r, cur_start_s;
  logic [NW-1:0]     best_len_r, best_len_s;
  logic [LW-1:0]     best_start_r, best_start_s;
  logic [LW-1:0]     centre_s;
  logic              go_s;

`ifdef NET_PHASE_SCHED_PERIODIC_EN
  localparam int TW = $clog2(RECAL_CYCLES);
  localparam logic [TW-1:0] RECAL_LAST = TW'(RECAL_CYCLES - 1);

  logic [TW-1:0] idle_tmr_r;
  logic          recal_s;

  // An external start and the timer trigger merge into a single request.
  assign recal_s = (state_r == ST_IDLE) && (idle_tmr_r == RECAL_LAST);
  assign go_s    = start | recal_s;

  // Idle timer: runs only in IDLE and restarts whenever a sweep begins.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      idle_tmr_r <= '0;
    end else if ((state_r == ST_IDLE) && go_s) begin
      idle_tmr_r <= '0;
    end else if (state_r == ST_IDLE) begin
      idle_tmr_r <= idle_tmr_r + 1'b1;
    end else begin
      idle_tmr_r <= idle_tmr_r;
    end
  end
`else
  assign go_s = start;
`endif

  // Next-state, counter, mask and run-scan decisions for the whole sweep.
  always_comb begin
    state_s      = state_r;
    tap_s        = tap_r;
    phase_s      = phase_r;
    saved_s      = saved_r;
    cnt_s        = cnt_r;
    good_s       = good_r;
    err_s        = err_r;
    mask_s       = mask_r;
    busy_s       = busy_r;
    done_s       = 1'b0;
    locked_s     = locked_r;
    best_s       = best_r;
    scan_s       = scan_r;
    cur_len_s    = cur_len_r;
    cur_start_s  = cur_start_r;
    best_len_s   = best_len_r;
    best_start_s = best_start_r;
    centre_s     = '0;
    case (state_r)
      ST_IDLE: begin
        if (go_s) begin
          saved_s = phase_r;
          tap_s   = '0;
          phase_s = '0;
          busy_s  = 1'b1;
          mask_s  = '0;
          cnt_s   = '0;
          state_s = ST_SETTLE;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SETTLE: begin
        if (cnt_r == SETTLE_LAST) begin
          cnt_s   = '0;
          good_s  = '0;
          err_s   = 1'b0;
          state_s = ST_MEASURE;
        end else begin
          cnt_s = cnt_r + 1'b1;
        end
      end
      ST_MEASURE: begin
        if (rx_end_evt && (good_r < GOOD_SAT)) begin
          good_s = good_r + 1'b1;
        end else begin
          good_s = good_r;
        end
        err_s = err_r | rx_err_evt;
        // The final window cycle's events count toward the verdict.
        if (cnt_r == WINDOW_LAST) begin
          mask_s[tap_r] = (good_s >= GOOD_SAT) && !err_s;
          cnt_s         = '0;
          state_s       = ST_NEXT;
        end else begin
          cnt_s = cnt_r + 1'b1;
        end
      end
      ST_NEXT: begin
        if (tap_r == TAP_LAST) begin
          scan_s       = '0;
          cur_len_s    = '0;
          cur_start_s  = '0;
          best_len_s   = '0;
          best_start_s = '0;
          state_s      = ST_SELECT;
        end else begin
          tap_s   = tap_r + 1'b1;
          phase_s = tap_r + 1'b1;
          state_s = ST_SETTLE;
        end
      end
      ST_SELECT: begin
        // Two passes over the mask so a run crossing tap 0 is seen whole.
        scan_s = scan_r + 1'b1;
        if (mask_r[scan_r[LW-1:0]]) begin
          if (cur_len_r == '0) begin
            cur_start_s = scan_r[LW-1:0];
          end else begin
            cur_start_s = cur_start_r;
          end
          if (cur_len_r == LEN_CAP) begin
            cur_len_s = cur_len_r;
          end else begin
            cur_len_s = cur_len_r + 1'b1;
          end
        end else begin
          cur_len_s = '0;
        end
        // Strictly longer wins, so ties keep the run found first.
        if (cur_len_s > best_len_r) begin
          best_len_s   = cur_len_s;
          best_start_s = cur_start_s;
        end else begin
          best_len_s   = best_len_r;
          best_start_s = best_start_r;
        end
        centre_s = best_start_s + LW'((best_len_s - 1'b1) >> 1);
        if (scan_r == SCAN_LAST) begin
          busy_s  = 1'b0;
          done_s  = 1'b1;
          state_s = ST_DONE;
          if (best_len_s == '0) begin
            phase_s  = saved_r;
            locked_s = 1'b0;
          end else if (best_len_s == LEN_CAP) begin
            phase_s  = '0;
            best_s   = '0;
            locked_s = 1'b1;
          end else begin
            phase_s  = centre_s;
            best_s   = centre_s;
            locked_s = 1'b1;
          end
        end else begin
          state_s = ST_SELECT;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
        busy_s  = 1'b0;
      end
    endcase
  end

  // State and datapath registers; reset aborts any sweep immediately.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r      <= ST_IDLE;
      tap_r        <= '0;
      phase_r      <= '0;
      saved_r      <= '0;
      cnt_r        <= '0;
      good_r       <= '0;
      err_r        <= 1'b0;
      mask_r       <= '0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      locked_r     <= 1'b0;
      best_r       <= '0;
      scan_r       <= '0;
      cur_len_r    <= '0;
      cur_start_r  <= '0;
      best_len_r   <= '0;
      best_start_r <= '0;
    end else begin
      state_r      <= state_s;
      tap_r        <= tap_s;
      phase_r      <= phase_s;
      saved_r      <= saved_s;
      cnt_r        <= cnt_s;
      good_r       <= good_s;
      err_r        <= err_s;
      mask_r       <= mask_s;
      busy_r       <= busy_s;
      done_r       <= done_s;
      locked_r     <= locked_s;
      best_r       <= best_s;
      scan_r       <= scan_s;
      cur_len_r    <= cur_len_s;
      cur_start_r  <= cur_start_s;
      best_len_r   <= best_len_s;
      best_start_r <= best_start_s;
    end
  end

  assign phase_shift = 8'(phase_r);
  assign best_phase  = 8'(best_r);
  assign busy        = busy_r;
  assign done        = done_r;
  assign locked      = locked_r;
  assign good_mask   = mask_r;

endmodule

// File: tb/tb_net_phase_scheduler.sv
`timescale 1ns/1ps
module tb_net_phase_scheduler;

  localparam int P       = 8;
  localparam int SC      = 4;
  localparam int WC      = 64;
  localparam int MP      = 4;
  localparam int RC      = 1000;
  localparam int TAP_CYC = SC + WC + 1;
  // Cycles from start to done, counting both the start cycle and the done cycle.
  localparam int LAT     = 1 + P * TAP_CYC + 2 * P + 1;

  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic         start = 1'b0;
  logic         rx_end_evt = 1'b0;
  logic         rx_err_evt = 1'b0;
  logic [7:0]   phase_shift;
  logic         busy;
  logic         done;
  logic         locked;
  logic [7:0]   best_phase;
  logic [P-1:0] good_mask;

  typedef struct {
    logic [7:0] mask;
    logic [7:0] phase;
    logic [7:0] best;
    logic       locked;
    int         start_cyc;
  } exp_t;

  exp_t sb[$];
  exp_t got_e;
  int   n_end[P];
  int   n_err[P];
  int   n_set[P];
  int   extra_start[3];
  int   checks = 0;
  int   passes = 0;
  int   done_cnt = 0;
  int   cyc = 0;
  int   last_done_cyc = 0;
  int   rose;

  net_phase_scheduler #(
    .PHASES(P), .SETTLE_CYCLES(SC), .WINDOW_CYCLES(WC),
    .MIN_PACKETS(MP), .RECAL_CYCLES(RC)
  ) dut (
    .clk(clk), .resetn(resetn), .start(start),
    .rx_end_evt(rx_end_evt), .rx_err_evt(rx_err_evt),
    .phase_shift(phase_shift), .busy(busy), .done(done),
    .locked(locked), .best_phase(best_phase), .good_mask(good_mask)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Monitor: every done pulse is matched against the oldest expected sweep result.
  always @(negedge clk) begin
    if (resetn && done) begin
      done_cnt++;
      last_done_cyc = cyc;
      if (sb.size() == 0) begin
        checks++;
        $display("FAIL unexpected_done: done=1 at cycle %0d with no sweep outstanding", cyc);
      end else begin
        got_e = sb.pop_front();
        check("good_mask", 32'(good_mask), 32'(got_e.mask));
        check("phase_shift", 32'(phase_shift), 32'(got_e.phase));
        check("best_phase", 32'(best_phase), 32'(got_e.best));
        check("locked", 32'(locked), 32'(got_e.locked));
        check("busy_at_done", 32'(busy), 32'd0);
        check("latency", 32'(cyc - got_e.start_cyc + 1), 32'(LAT));
      end
    end
  end

  task automatic clear_tables();
    for (int t = 0; t < P; t++) begin
      n_end[t] = 0;
      n_err[t] = 0;
      n_set[t] = 0;
    end
    for (int k = 0; k < 3; k++) extra_start[k] = -1;
  endtask

  // Drive rx events for sweep-relative cycle c from the per-tap tables.
  task automatic drive_events(input int c);
    int t, o, m;
    rx_end_evt = 1'b0;
    rx_err_evt = 1'b0;
    t = (c - 1) / TAP_CYC;
    o = (c - 1) % TAP_CYC;
    if ((c >= 1) && (t < P)) begin
      if (o < SC) begin
        rx_end_evt = (o < n_set[t]);
      end else if (o < SC + WC) begin
        m = o - SC;
        rx_end_evt = ((m % 4) == 2) && ((m / 4) < n_end[t]);
        rx_err_evt = (m == 2) && (n_err[t] > 0);
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_phase"}, 32'(phase_shift), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_locked"}, 32'(locked), 32'd0);
    check({tag, "_best"}, 32'(best_phase), 32'd0);
    check({tag, "_mask"}, 32'(good_mask), 32'd0);
  endtask

  task automatic run_sweep(input logic [7:0] em, input logic [7:0] ep, input logic [7:0] eb,
                           input logic el, input int abort_at);
    exp_t e;
    int   d0;
    @(posedge clk); #1;
    e.mask = em; e.phase = ep; e.best = eb; e.locked = el; e.start_cyc = cyc;
    sb.push_back(e);
    d0 = done_cnt;
    start = 1'b1;
    for (int c = 1; c <= LAT + 1; c++) begin
      @(posedge clk); #1;
      start = (c == extra_start[0]) || (c == extra_start[1]) || (c == extra_start[2]);
      drive_events(c);
      if (c == abort_at) begin
        resetn = 1'b0;
        start = 1'b0;
        rx_end_evt = 1'b0;
        rx_err_evt = 1'b0;
        #1;
        check_all_zero("abort");
        sb.delete();
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;
        return;
      end
    end
    start = 1'b0;
    rx_end_evt = 1'b0;
    rx_err_evt = 1'b0;
    check("done_seen", 32'(sb.size()), 32'd0);
    if (sb.size() != 0) sb.delete();
    check("single_done", 32'(done_cnt - d0), 32'd1);
    check("idle_after_done", 32'(busy), 32'd0);
  endtask

  initial begin
    clear_tables();
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    resetn = 1'b1;

    // Taps 2..5 good -> centre 3.
    clear_tables();
    for (int t = 2; t <= 5; t++) n_end[t] = 5;
    run_sweep(8'h3C, 8'd3, 8'd3, 1'b1, -1);

    // Run wrapping through tap 0: taps 6,7,0,1 -> centre 7.
    clear_tables();
    n_end[6] = 5; n_end[7] = 5; n_end[0] = 5; n_end[1] = 5;
    run_sweep(8'hC3, 8'd7, 8'd7, 1'b1, -1);

    // Taps 4..6 good -> phase 5, setting up the restore case.
    clear_tables();
    for (int t = 4; t <= 6; t++) n_end[t] = 4;
    run_sweep(8'h70, 8'd5, 8'd5, 1'b1, -1);

    // No events: phase restored to 5, best_phase kept, not locked.
    clear_tables();
    run_sweep(8'h00, 8'd5, 8'd5, 1'b0, -1);

    // Error on tap 4, 3 pulses on tap 6, settle-only pulses on tap 7.
    clear_tables();
    for (int t = 2; t <= 5; t++) n_end[t] = 5;
    n_err[4] = 1;
    n_end[6] = 3;
    n_set[7] = 4;
    run_sweep(8'h2C, 8'd2, 8'd2, 1'b1, -1);

    // All taps good -> phase 0; start pulses while busy and in DONE are ignored.
    clear_tables();
    for (int t = 0; t < P; t++) n_end[t] = 4;
    extra_start[0] = 100; extra_start[1] = 300; extra_start[2] = LAT - 1;
    run_sweep(8'hFF, 8'd0, 8'd0, 1'b1, -1);

    // Asynchronous reset in the middle of tap 3's measurement window.
    clear_tables();
    for (int t = 1; t <= 3; t++) n_end[t] = 5;
    run_sweep(8'h0E, 8'd2, 8'd2, 1'b1, 3 * TAP_CYC + SC + 20);
    #1;
    check_all_zero("after_abort");

    // Fresh sweep after the abort completes normally.
    clear_tables();
    for (int t = 1; t <= 3; t++) n_end[t] = 5;
    run_sweep(8'h0E, 8'd2, 8'd2, 1'b1, -1);

    // Idle behaviour after the last done.
    rose = -1;
    for (int i = 0; (i < RC + 100) && (rose < 0); i++) begin
      @(negedge clk);
      if (busy) rose = cyc - last_done_cyc;
    end
`ifdef NET_PHASE_SCHED_PERIODIC_EN
    check("recal_delay", 32'(rose), 32'(RC + 1));
`else
    check("no_auto_sweep", 32'(rose), 32'hFFFF_FFFF);
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
